// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: captures receiver bytes into a circular buffer and presents them first-word-fall-through.
// Optional fill-threshold flag (THRESH parameter, rx_thresh port) enabled by defining UART_RX_FIFO_THRESH_EN.
module uart_rx_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4
`ifdef UART_RX_FIFO_THRESH_EN
  ,
  parameter int unsigned THRESH = 12
`endif
) (
  input  logic                  sys_clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_data_ready,
  output logic [7:0]            rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  full,
  output logic                  overrun,
`ifdef UART_RX_FIFO_THRESH_EN
  output logic                  rx_thresh,
`endif
  input  logic                  overrun_clr
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  localparam int unsigned LW    = DEPTH_LOG2 + 1;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  push;
  logic                  pop;
  logic                  drop;

  // Status decodes from the registered count
  assign rd_valid = (level != '0);
  assign full     = (level == LW'(DEPTH));
  assign rd_data  = rd_valid ? mem[rd_ptr] : 8'h00;

`ifdef UART_RX_FIFO_THRESH_EN
  assign rx_thresh = (level >= LW'(THRESH));
`endif

  // A pop frees the slot being written, so a full FIFO still accepts a byte when popped
  assign pop  = rd_valid & rd_ready;
  assign push = rx_data_ready & (~full | pop);
  assign drop = rx_data_ready & full & ~pop;

  // Storage array is intentionally not reset
  always_ff @(posedge sys_clk) begin
    if (push && !reset) begin
      mem[wr_ptr] <= rx_data;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      overrun <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      end
      if (push && !pop) begin
        level <= level + LW'(1);
      end else if (pop && !push) begin
        level <= level - LW'(1);
      end
      // Set takes priority over a same-cycle clear
      if (drop) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: table-driven cycle vectors plus directed fill, overrun and wrap sequences.
module tb_uart_rx_fifo;

  localparam int unsigned DL = 4;
  localparam int unsigned LW = DL + 1;

  logic          sys_clk = 1'b0;
  logic          reset;
  logic [7:0]    rx_data;
  logic          rx_data_ready;
  logic [7:0]    rd_data;
  logic          rd_valid;
  logic          rd_ready;
  logic [LW-1:0] level;
  logic          full;
  logic          overrun;
  logic          overrun_clr;
`ifdef UART_RX_FIFO_THRESH_EN
  logic          rx_thresh;
`endif

  int errors = 0;
  int checks = 0;

  always #5 sys_clk = ~sys_clk;

  uart_rx_fifo #(
    .DEPTH_LOG2(DL)
`ifdef UART_RX_FIFO_THRESH_EN
    ,
    .THRESH(12)
`endif
  ) dut (
    .sys_clk      (sys_clk),
    .reset        (reset),
    .rx_data      (rx_data),
    .rx_data_ready(rx_data_ready),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .level        (level),
    .full         (full),
    .overrun      (overrun),
`ifdef UART_RX_FIFO_THRESH_EN
    .rx_thresh    (rx_thresh),
`endif
    .overrun_clr  (overrun_clr)
  );

  typedef struct {
    logic       rst;
    logic       wr;
    logic [7:0] d;
    logic       rr;
    logic       clr;
    logic       e_valid;
    logic [7:0] e_data;
    int         e_level;
    logic       e_full;
    logic       e_ovr;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, let the edge pass, sample 1ns after it
  task automatic step(input logic r, input logic wr, input logic [7:0] d,
                      input logic rr, input logic clr);
    reset         = r;
    rx_data_ready = wr;
    rx_data       = d;
    rd_ready      = rr;
    overrun_clr   = clr;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic add(input logic r, input logic wr, input logic [7:0] d, input logic rr,
                     input logic clr, input logic ev, input logic [7:0] ed, input int el,
                     input logic ef, input logic eo);
    vec_t v;
    v.rst = r; v.wr = wr; v.d = d; v.rr = rr; v.clr = clr;
    v.e_valid = ev; v.e_data = ed; v.e_level = el; v.e_full = ef; v.e_ovr = eo;
    vecs.push_back(v);
  endtask

  task automatic chk_state(input string tag, input logic ev, input logic [7:0] ed,
                           input int el, input logic ef, input logic eo);
    chk({tag, ".rd_valid"}, int'(rd_valid), int'(ev));
    chk({tag, ".rd_data"},  int'(rd_data),  int'(ed));
    chk({tag, ".level"},    int'(level),    el);
    chk({tag, ".full"},     int'(full),     int'(ef));
    chk({tag, ".overrun"},  int'(overrun),  int'(eo));
  endtask

  initial begin
    //  rst wr  data   rr  clr | valid data  lvl full ovr
    add(1, 1, 8'h55, 1, 0,     0, 8'h00, 0, 0, 0);
    add(1, 1, 8'h55, 1, 1,     0, 8'h00, 0, 0, 0);
    add(0, 1, 8'hA5, 0, 0,     1, 8'hA5, 1, 0, 0);
    add(0, 1, 8'h3C, 0, 0,     1, 8'hA5, 2, 0, 0);
    add(0, 1, 8'h00, 0, 0,     1, 8'hA5, 3, 0, 0);
    add(0, 1, 8'hFF, 0, 0,     1, 8'hA5, 4, 0, 0);
    add(0, 0, 8'h11, 0, 0,     1, 8'hA5, 4, 0, 0);
    add(0, 0, 8'h00, 1, 0,     1, 8'h3C, 3, 0, 0);
    add(0, 0, 8'h00, 1, 0,     1, 8'h00, 2, 0, 0);
    add(0, 0, 8'h00, 1, 0,     1, 8'hFF, 1, 0, 0);
    add(0, 0, 8'h00, 1, 0,     0, 8'h00, 0, 0, 0);
    add(0, 0, 8'h00, 1, 0,     0, 8'h00, 0, 0, 0);
    add(0, 1, 8'h5A, 1, 0,     1, 8'h5A, 1, 0, 0);
    add(0, 1, 8'h6B, 0, 0,     1, 8'h5A, 2, 0, 0);
    add(1, 1, 8'h7C, 1, 0,     0, 8'h00, 0, 0, 0);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].wr, vecs[i].d, vecs[i].rr, vecs[i].clr);
      chk_state($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_data,
                vecs[i].e_level, vecs[i].e_full, vecs[i].e_ovr);
    end

    // Fill with 01..10, then 11 is dropped and flags overrun
    for (int i = 1; i <= 16; i++) begin
      step(0, 1, 8'(i), 0, 0);
    end
    chk_state("fill16", 1, 8'h01, 16, 1, 0);
    step(0, 1, 8'h11, 0, 0);
    chk_state("drop17", 1, 8'h01, 16, 1, 1);
    step(0, 0, 8'h00, 0, 1);
    chk_state("ovr_clr", 1, 8'h01, 16, 1, 0);
    step(0, 1, 8'h99, 0, 1);
    chk_state("drop_and_clr", 1, 8'h01, 16, 1, 1);
    step(0, 0, 8'h00, 0, 1);
    chk("ovr_clr2", int'(overrun), 0);

    // Full with simultaneous push and pop: both accepted, no overrun
    step(0, 1, 8'h77, 1, 0);
    chk_state("full_push_pop", 1, 8'h02, 16, 1, 0);
    for (int i = 2; i <= 16; i++) begin
      chk($sformatf("drain%0d.data", i), int'(rd_data), i);
      chk($sformatf("drain%0d.valid", i), int'(rd_valid), 1);
      step(0, 0, 8'h00, 1, 0);
    end
    chk("drain_last.data", int'(rd_data), 8'h77);
    chk("drain_last.level", int'(level), 1);
    step(0, 0, 8'h00, 1, 0);
    chk_state("drained", 0, 8'h00, 0, 0, 0);

    // Wrap-around: streaming push+pop every cycle keeps level at 1
    step(0, 1, 8'h80, 0, 0);
    for (int i = 0; i < 40; i++) begin
      chk($sformatf("wrap%0d.data", i), int'(rd_data), 8'h80 + i);
      step(0, 1, 8'(8'h81 + i), 1, 0);
      chk($sformatf("wrap%0d.level", i), int'(level), 1);
    end
    chk("wrap_end.data", int'(rd_data), 8'h80 + 40);
    step(0, 0, 8'h00, 1, 0);
    chk_state("wrap_empty", 0, 8'h00, 0, 0, 0);

`ifdef UART_RX_FIFO_THRESH_EN
    step(1, 0, 8'h00, 0, 0);
    chk("thr_reset", int'(rx_thresh), 0);
    for (int i = 1; i <= 11; i++) begin
      step(0, 1, 8'(i), 0, 0);
    end
    chk("thr_11", int'(rx_thresh), 0);
    step(0, 1, 8'h0C, 0, 0);
    chk("thr_12", int'(rx_thresh), 1);
    step(0, 0, 8'h00, 1, 0);
    chk("thr_pop", int'(rx_thresh), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
